lmac_rx_xgmii: RTL and testbench

10G receive datapath of the LMAC; the counterpart to the TX function.
- Consumes 64-bit XGMII (8 lanes, lane 0 = first byte).
- Strips preamble/SFD, delimits frames on Start/Terminate and checks CRC32 and length.
- Buffers frames in a RX FIFO with commit/rollback, so only good frames become readable.
- Maintains received-packet/byte/error statistics for the register block.

---
 rtl/lmac_rx_pkg.sv | 25 ++
 rtl/lmac_rx_crc32_d64.sv | 23 ++
 rtl/lmac_rx_xgmii.sv | 178 +++++++++++++++++
 tb/tb_lmac_rx_xgmii.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmac_rx_pkg.sv
// rtl/lmac_rx_pkg.sv - shared constants and types for the 10G LMAC receive path
package lmac_rx_pkg;

    localparam logic [7:0]  XGMII_IDLE  = 8'h07;
    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  XGMII_PRE   = 8'h55;
    localparam logic [7:0]  XGMII_SFD   = 8'hD5;

    localparam logic [63:0] START_WORD    = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_IDLE = 2'd0;
    localparam rx_state_t ST_DATA = 2'd1;
    localparam rx_state_t ST_DROP = 2'd2;

    typedef struct packed {
        logic [63:0] data;
        logic        eop;
        logic [3:0]  nbytes;
    } rx_entry_t;

endpackage

// File: rtl/lmac_rx_crc32_d64.sv
// rtl/lmac_rx_crc32_d64.sv - combinational reflected CRC32 update over 0..8 low bytes of a word
module lmac_rx_crc32_d64
    import lmac_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                crc_out = crc_out ^ {24'd0, data[8*i +: 8]};
                for (int b = 0; b < 8; b++) begin
                    crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
                end
            end
        end
    end

endmodule

// File: rtl/lmac_rx_xgmii.sv
// rtl/lmac_rx_xgmii.sv - XGMII frame receiver with CRC/length check and commit/rollback RX FIFO
module lmac_rx_xgmii
    import lmac_rx_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode_10g,
    input  logic [63:0]             xgmii_rxd,
    input  logic [7:0]              xgmii_rxc,
    input  logic                    rx_re,
    output logic [63:0]             rx_dout,
    output logic                    rx_dout_eop,
    output logic [3:0]              rx_dout_nbytes,
    output logic                    rx_empty,
    output logic [$clog2(DEPTH):0]  rx_rused_qwd,
    output logic [31:0]             rx_pkt_rcvd,
    output logic [31:0]             rx_byte_rcvd,
    output logic [31:0]             rx_err_cnt,
    output logic [31:0]             rx_ovf_cnt
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, commit_ptr, rd_ptr;
    rx_state_t       state;
    logic [31:0]     crc;
    logic [15:0]     len;
    logic [63:0]     hold;
    logic            hold_valid;

    logic            term;
    logic [3:0]      term_k;
    logic [7:0]      term_byte;
    logic [3:0]      crc_nbytes;
    logic [31:0]     crc_next;
    logic [16:0]     len_sum;
    logic [15:0]     len_next;
    logic            frame_good;
    logic            we_a, we_b, ovf;
    logic [AW-1:0]   addr_b, wr_ptr_end;
    rx_entry_t       ent_a, ent_b;

    // Terminate: lowest control lane holds 0xFD and every lane above it is control too
    always_comb begin
        term_k    = 4'd0;
        term_byte = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i]) begin
                term_k    = 4'(i);
                term_byte = xgmii_rxd[8*i +: 8];
            end
        end
        term = (xgmii_rxc != 8'h00) && (xgmii_rxc == (8'hFF << term_k)) && (term_byte == XGMII_TERM);
    end

    assign crc_nbytes = (xgmii_rxc == 8'h00) ? 4'd8 : term_k;

    lmac_rx_crc32_d64 u_crc (
        .crc_in  (crc),
        .data    (xgmii_rxd),
        .nbytes  (crc_nbytes),
        .crc_out (crc_next)
    );

    assign len_sum    = {1'b0, len} + {13'd0, crc_nbytes};
    assign len_next   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign frame_good = (crc_next == CRC_RESIDUE) && (len_next >= 16'(MIN_LEN)) && (len_next <= 16'(MAX_LEN));

    // Port A drains the hold register; port B takes the partial tail word of a T cycle
    always_comb begin
        we_a  = 1'b0;
        we_b  = 1'b0;
        ent_a = '{data: hold, eop: 1'b0, nbytes: 4'd8};
        ent_b = '{data: xgmii_rxd, eop: 1'b1, nbytes: term_k};
        if (state == ST_DATA && mode_10g) begin
            if (xgmii_rxc == 8'h00) begin
                we_a = hold_valid;
            end else if (term) begin
                we_a      = hold_valid;
                we_b      = (term_k != 4'd0);
                ent_a.eop = (term_k == 4'd0);
            end
        end
        addr_b     = wr_ptr + AW'(we_a);
        wr_ptr_end = addr_b + AW'(we_b);
        ovf        = (we_a && (wr_ptr + 1'b1 == rd_ptr)) || (we_b && (addr_b + 1'b1 == rd_ptr));
    end

    always_ff @(posedge clk) begin
        if (we_a && !ovf) mem[wr_ptr] <= ent_a;
        if (we_b && !ovf) mem[addr_b] <= ent_b;
    end

    assign rx_empty     = (commit_ptr == rd_ptr);
    assign rx_rused_qwd = {1'b0, AW'(commit_ptr - rd_ptr)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            rd_ptr         <= '0;
            crc            <= 32'hFFFFFFFF;
            len            <= 16'd0;
            hold           <= 64'd0;
            hold_valid     <= 1'b0;
            rx_dout        <= 64'd0;
            rx_dout_eop    <= 1'b0;
            rx_dout_nbytes <= 4'd0;
            rx_pkt_rcvd    <= 32'd0;
            rx_byte_rcvd   <= 32'd0;
            rx_err_cnt     <= 32'd0;
            rx_ovf_cnt     <= 32'd0;
        end else begin
            if (rx_re && !rx_empty) begin
                rx_dout        <= mem[rd_ptr].data;
                rx_dout_eop    <= mem[rd_ptr].eop;
                rx_dout_nbytes <= mem[rd_ptr].nbytes;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (mode_10g && xgmii_rxc == 8'h01 && xgmii_rxd == START_WORD) begin
                        state      <= ST_DATA;
                        crc        <= 32'hFFFFFFFF;
                        len        <= 16'd0;
                        hold_valid <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (!mode_10g) begin
                        wr_ptr     <= commit_ptr;
                        rx_err_cnt <= rx_err_cnt + 32'd1;
                        state      <= ST_IDLE;
                    end else if (ovf) begin
                        wr_ptr     <= commit_ptr;
                        rx_ovf_cnt <= rx_ovf_cnt + 32'd1;
                        state      <= ST_DROP;
                    end else if (xgmii_rxc == 8'h00) begin
                        wr_ptr     <= wr_ptr_end;
                        hold       <= xgmii_rxd;
                        hold_valid <= 1'b1;
                        crc        <= crc_next;
                        len        <= len_next;
                    end else if (term) begin
                        state      <= ST_IDLE;
                        hold_valid <= 1'b0;
                        if (frame_good) begin
                            wr_ptr       <= wr_ptr_end;
                            commit_ptr   <= wr_ptr_end;
                            rx_pkt_rcvd  <= rx_pkt_rcvd + 32'd1;
                            rx_byte_rcvd <= rx_byte_rcvd + {16'd0, len_next};
                        end else begin
                            wr_ptr     <= commit_ptr;
                            rx_err_cnt <= rx_err_cnt + 32'd1;
                        end
                    end else begin
                        wr_ptr     <= commit_ptr;
                        rx_err_cnt <= rx_err_cnt + 32'd1;
                        state      <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!mode_10g || term || xgmii_rxc == 8'hFF) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmac_rx_xgmii.sv
// tb/tb_lmac_rx_xgmii.sv - directed self-checking bench for lmac_rx_xgmii
module tb_lmac_rx_xgmii;
    import lmac_rx_pkg::*;

    localparam logic [63:0] IDLE_WORD = {8{XGMII_IDLE}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_a = 1'b1;
    logic        mode_b = 1'b0;
    logic [63:0] xgmii_rxd = IDLE_WORD;
    logic [7:0]  xgmii_rxc = 8'hFF;
    logic        rx_re_a = 1'b0;
    logic        rx_re_b = 1'b0;

    logic [63:0] rx_dout, rx_dout16;
    logic        rx_dout_eop, rx_dout_eop16;
    logic [3:0]  rx_dout_nbytes, rx_dout_nbytes16;
    logic        rx_empty, rx_empty16;
    logic [8:0]  rx_rused_qwd;
    logic [4:0]  rx_rused_qwd16;
    logic [31:0] rx_pkt_rcvd, rx_byte_rcvd, rx_err_cnt, rx_ovf_cnt;
    logic [31:0] rx_pkt_rcvd16, rx_byte_rcvd16, rx_err_cnt16, rx_ovf_cnt16;

    int total = 0;
    int bad = 0;

    rx_entry_t exp_q [$];

    typedef struct {
        int len;
        bit bad_fcs;
        bit good;
        int words;
        int pkt;
        int err;
        int bytes;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    lmac_rx_xgmii #(.DEPTH(256), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_10g       (mode_a),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .rx_re          (rx_re_a),
        .rx_dout        (rx_dout),
        .rx_dout_eop    (rx_dout_eop),
        .rx_dout_nbytes (rx_dout_nbytes),
        .rx_empty       (rx_empty),
        .rx_rused_qwd   (rx_rused_qwd),
        .rx_pkt_rcvd    (rx_pkt_rcvd),
        .rx_byte_rcvd   (rx_byte_rcvd),
        .rx_err_cnt     (rx_err_cnt),
        .rx_ovf_cnt     (rx_ovf_cnt)
    );

    lmac_rx_xgmii #(.DEPTH(16), .MIN_LEN(64), .MAX_LEN(1518)) dut16 (
        .clk            (clk),
        .rst            (rst),
        .mode_10g       (mode_b),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .rx_re          (rx_re_b),
        .rx_dout        (rx_dout16),
        .rx_dout_eop    (rx_dout_eop16),
        .rx_dout_nbytes (rx_dout_nbytes16),
        .rx_empty       (rx_empty16),
        .rx_rused_qwd   (rx_rused_qwd16),
        .rx_pkt_rcvd    (rx_pkt_rcvd16),
        .rx_byte_rcvd   (rx_byte_rcvd16),
        .rx_err_cnt     (rx_err_cnt16),
        .rx_ovf_cnt     (rx_ovf_cnt16)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(IDLE_WORD, 8'hFF);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // n bytes including FCS; push queues the expected FIFO words for dut
    task automatic send_frame(input int n, input bit bad_fcs, input bit push);
        logic [7:0]  b [$];
        logic [31:0] c;
        logic [63:0] d;
        int          k;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b.push_back(8'((i * 7 + n) & 255));
            c = crc_byte(c, b[i]);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) b.push_back(c[8*j +: 8]);
        if (bad_fcs) b[n-4] = b[n-4] ^ 8'h01;
        put(START_WORD, 8'h01);
        k = n % 8;
        for (int w = 0; w < n / 8; w++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = b[8*w + j];
            put(d, 8'h00);
            if (push) exp_q.push_back('{data: d, eop: (k == 0 && w == n / 8 - 1), nbytes: 4'd8});
        end
        d = IDLE_WORD;
        for (int j = 0; j < k; j++) d[8*j +: 8] = b[8*(n/8) + j];
        d[8*k +: 8] = XGMII_TERM;
        put(d, 8'hFF << k);
        if (push && k > 0) exp_q.push_back('{data: d, eop: 1'b1, nbytes: 4'(k)});
    endtask

    task automatic read_word();
        rx_re_a = 1'b1;
        @(posedge clk);
        #1;
        rx_re_a = 1'b0;
    endtask

    task automatic drain();
        rx_entry_t   e;
        logic [63:0] m;
        e = '0;
        m = '1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_word();
            m = (e.nbytes == 4'd8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * e.nbytes)) - 64'd1);
            chk("rd_data", rx_dout & m, e.data & m);
            chk("rd_eop", {63'd0, rx_dout_eop}, {63'd0, e.eop});
            chk("rd_nbytes", {60'd0, rx_dout_nbytes}, {60'd0, e.nbytes});
        end
        chk("empty_after_drain", {63'd0, rx_empty}, 64'd1);
        read_word();
        chk("read_when_empty_holds", rx_dout & m, e.data & m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{len: 64,   bad_fcs: 1'b0, good: 1'b1, words: 8,   pkt: 1, err: 0, bytes: 64};
        vt[1] = '{len: 69,   bad_fcs: 1'b0, good: 1'b1, words: 9,   pkt: 2, err: 0, bytes: 133};
        vt[2] = '{len: 64,   bad_fcs: 1'b1, good: 1'b0, words: 0,   pkt: 2, err: 1, bytes: 133};
        vt[3] = '{len: 40,   bad_fcs: 1'b0, good: 1'b0, words: 0,   pkt: 2, err: 2, bytes: 133};
        vt[4] = '{len: 1519, bad_fcs: 1'b0, good: 1'b0, words: 0,   pkt: 2, err: 3, bytes: 133};
        vt[5] = '{len: 1518, bad_fcs: 1'b0, good: 1'b1, words: 190, pkt: 3, err: 3, bytes: 1651};
        vt[6] = '{len: 65,   bad_fcs: 1'b0, good: 1'b1, words: 9,   pkt: 4, err: 3, bytes: 1716};
        vt[7] = '{len: 71,   bad_fcs: 1'b0, good: 1'b1, words: 9,   pkt: 5, err: 3, bytes: 1787};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_empty", {63'd0, rx_empty}, 64'd1);
        chk("reset_rused", {55'd0, rx_rused_qwd}, 64'd0);
        chk("reset_dout", rx_dout, 64'd0);
        chk("reset_pkt", {32'd0, rx_pkt_rcvd}, 64'd0);
        chk("reset_err", {32'd0, rx_err_cnt}, 64'd0);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].len, vt[i].bad_fcs, vt[i].good);
            idle(2);
            chk($sformatf("v%0d_rused", i), {55'd0, rx_rused_qwd}, 64'(vt[i].words));
            chk($sformatf("v%0d_pkt", i), {32'd0, rx_pkt_rcvd}, 64'(vt[i].pkt));
            chk($sformatf("v%0d_err", i), {32'd0, rx_err_cnt}, 64'(vt[i].err));
            chk($sformatf("v%0d_byte", i), {32'd0, rx_byte_rcvd}, 64'(vt[i].bytes));
            chk($sformatf("v%0d_ovf", i), {32'd0, rx_ovf_cnt}, 64'd0);
            if (vt[i].good) drain();
            else chk($sformatf("v%0d_empty", i), {63'd0, rx_empty}, 64'd1);
        end

        // back-to-back frames with no idle between T and the next Start
        send_frame(69, 1'b0, 1'b1);
        send_frame(64, 1'b0, 1'b1);
        idle(2);
        chk("b2b_rused", {55'd0, rx_rused_qwd}, 64'd17);
        chk("b2b_pkt", {32'd0, rx_pkt_rcvd}, 64'd7);
        chk("b2b_byte", {32'd0, rx_byte_rcvd}, 64'd1920);
        drain();

        // stray control byte mid-frame, then data words that must be ignored in DROP
        put(START_WORD, 8'h01);
        put(64'h1122334455667788, 8'h00);
        put(64'h99AABBCCDDEEFF00, 8'h00);
        put(64'h0102039C04050607, 8'h10);
        put(64'h0F0E0D0C0B0A0908, 8'h00);
        put(64'h1716151413121110, 8'h00);
        idle(1);
        chk("ctrl_err", {32'd0, rx_err_cnt}, 64'd4);
        chk("ctrl_rused", {55'd0, rx_rused_qwd}, 64'd0);
        send_frame(64, 1'b0, 1'b1);
        idle(2);
        chk("ctrl_next_pkt", {32'd0, rx_pkt_rcvd}, 64'd8);
        chk("ctrl_next_rused", {55'd0, rx_rused_qwd}, 64'd8);
        drain();

        // receiver disabled mid-frame
        put(START_WORD, 8'h01);
        put(64'h1122334455667788, 8'h00);
        put(64'h2233445566778899, 8'h00);
        put(64'h33445566778899AA, 8'h00);
        mode_a = 1'b0;
        put(IDLE_WORD, 8'hFF);
        mode_a = 1'b1;
        chk("mode_err", {32'd0, rx_err_cnt}, 64'd5);
        chk("mode_rused", {55'd0, rx_rused_qwd}, 64'd0);
        send_frame(64, 1'b0, 1'b1);
        idle(2);
        chk("mode_next_pkt", {32'd0, rx_pkt_rcvd}, 64'd9);
        chk("mode_next_byte", {32'd0, rx_byte_rcvd}, 64'd2048);
        drain();

        // overflow on the 16-deep instance
        mode_a = 1'b0;
        mode_b = 1'b1;
        send_frame(200, 1'b0, 1'b0);
        idle(2);
        chk("ovf_cnt", {32'd0, rx_ovf_cnt16}, 64'd1);
        chk("ovf_rused", {59'd0, rx_rused_qwd16}, 64'd0);
        chk("ovf_err", {32'd0, rx_err_cnt16}, 64'd0);
        chk("ovf_pkt", {32'd0, rx_pkt_rcvd16}, 64'd0);
        send_frame(64, 1'b0, 1'b0);
        idle(2);
        chk("ovf_next_rused", {59'd0, rx_rused_qwd16}, 64'd8);
        chk("ovf_next_pkt", {32'd0, rx_pkt_rcvd16}, 64'd1);
        chk("ovf_next_byte", {32'd0, rx_byte_rcvd16}, 64'd64);
        chk("ovf_other_pkt", {32'd0, rx_pkt_rcvd}, 64'd9);
        mode_b = 1'b0;
        mode_a = 1'b1;

        // asynchronous reset in the middle of a frame with committed data pending
        send_frame(64, 1'b0, 1'b0);
        put(START_WORD, 8'h01);
        put(64'h1122334455667788, 8'h00);
        put(64'h2233445566778899, 8'h00);
        rst = 1'b1;
        #1;
        chk("rst_pkt", {32'd0, rx_pkt_rcvd}, 64'd0);
        chk("rst_err", {32'd0, rx_err_cnt}, 64'd0);
        chk("rst_byte", {32'd0, rx_byte_rcvd}, 64'd0);
        chk("rst_empty", {63'd0, rx_empty}, 64'd1);
        chk("rst_rused", {55'd0, rx_rused_qwd}, 64'd0);
        chk("rst_dout", rx_dout, 64'd0);
        chk("rst_ovf16", {32'd0, rx_ovf_cnt16}, 64'd0);
        chk("rst_empty16", {63'd0, rx_empty16}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        idle(1);
        send_frame(64, 1'b0, 1'b1);
        idle(2);
        chk("post_rst_pkt", {32'd0, rx_pkt_rcvd}, 64'd1);
        chk("post_rst_rused", {55'd0, rx_rused_qwd}, 64'd8);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
